// File: rtl/header_bank_buffer.sv
// header_bank_buffer
// Double-buffered byte store for the block header. A byte-serial writer fills
// the back bank one addressed byte at a time while the hashing core reads the
// stable front bank. Per-byte written flags track header completeness; on a
// consumer request with a complete back bank the banks swap in one cycle.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   i_data_en   write strobe, one byte per cycle
//   i_data      write byte
//   i_data_sel  byte address of i_data
//   i_clear     discard back-bank contents (highest priority)
//   i_take      promote a full back bank to front
//   o_full      back bank holds all NUM_BYTES bytes
//   o_valid     front bank holds a promoted header
//   o_err       one-cycle pulse after a rejected write
//   o_count     distinct bytes written in the back bank
//   chunk_1     front bytes [CHUNK1_BYTES-1:0], byte 0 in the low bits
//   chunk_2     front bytes [NUM_BYTES-1:CHUNK1_BYTES]
//   difficulty  front bytes [TARGET_OFS +: TARGET_BYTES]
//
// Back-bank states:
//   state      | meaning
//   ST_EMPTY   | no bytes written
//   ST_FILLING | some but not all bytes written
//   ST_FULL    | every byte written, ready to swap
module header_bank_buffer #(
  parameter int NUM_BYTES    = 80,
  parameter int ADDR_W       = 7,
  parameter int CHUNK1_BYTES = 64,
  parameter int TARGET_OFS   = 72,
  parameter int TARGET_BYTES = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_data_en,
  input  logic [7:0]                            i_data,
  input  logic [ADDR_W-1:0]                     i_data_sel,
  input  logic                                  i_clear,
  input  logic                                  i_take,
  output logic                                  o_full,
  output logic                                  o_valid,
  output logic                                  o_err,
  output logic [ADDR_W:0]                       o_count,
  output logic [CHUNK1_BYTES*8-1:0]             chunk_1,
  output logic [(NUM_BYTES-CHUNK1_BYTES)*8-1:0] chunk_2,
  output logic [TARGET_BYTES*8-1:0]             difficulty
);

  localparam logic [ADDR_W:0] NUM_W = (ADDR_W+1)'(NUM_BYTES);
  localparam logic [ADDR_W:0] ONE_W = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [1:0][NUM_BYTES-1:0][7:0] bank_q, bank_d;
  logic [NUM_BYTES-1:0]           flag_q, flag_d;
  logic [ADDR_W:0]                count_q, count_d;
  logic                           ptr_q, ptr_d;
  logic                           valid_q, valid_d;
  logic                           err_q, err_d;

  logic in_range;
  logic swap;
  logic wr_acc;
  logic back_sel;

  always_comb begin
    in_range = ({1'b0, i_data_sel} < NUM_W);
    swap     = i_take && (state_q == ST_FULL) && !i_clear;
    // A full bank still accepts a write when it swaps in the same cycle.
    wr_acc   = i_data_en && in_range && !i_clear && ((state_q != ST_FULL) || swap);
    // During a swap the old front becomes the back bank and takes the write.
    back_sel = swap ? ptr_q : ~ptr_q;
    ptr_d    = ptr_q ^ swap;
    valid_d  = valid_q | swap;
    err_d    = i_data_en && !i_clear && (!in_range || ((state_q == ST_FULL) && !swap));

    bank_d  = bank_q;
    flag_d  = flag_q;
    count_d = count_q;

    if (i_clear) begin
      flag_d  = '0;
      count_d = '0;
    end else begin
      if (swap) begin
        flag_d  = '0;
        count_d = '0;
      end
      if (wr_acc) begin
        bank_d[back_sel][i_data_sel] = i_data;
        if (!flag_d[i_data_sel]) begin
          flag_d[i_data_sel] = 1'b1;
          count_d            = count_d + ONE_W;
        end
      end
    end

    state_d = ST_FILLING;
    if (count_d == '0) begin
      state_d = ST_EMPTY;
    end else if (count_d == NUM_W) begin
      state_d = ST_FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      bank_q  <= '0;
      flag_q  <= '0;
      count_q <= '0;
      ptr_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      flag_q  <= flag_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign o_full     = (state_q == ST_FULL);
  assign o_valid    = valid_q;
  assign o_err      = err_q;
  assign o_count    = count_q;
  assign chunk_1    = bank_q[ptr_q][CHUNK1_BYTES-1:0];
  assign chunk_2    = bank_q[ptr_q][NUM_BYTES-1:CHUNK1_BYTES];
  assign difficulty = bank_q[ptr_q][TARGET_OFS +: TARGET_BYTES];

endmodule

// File: tb/tb_header_bank_buffer.sv
module tb_header_bank_buffer;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_data_en = 1'b0;
  logic [7:0]    i_data = 8'h00;
  logic [6:0]    i_data_sel = '0;
  logic          i_clear = 1'b0;
  logic          i_take = 1'b0;
  logic          o_full, o_valid, o_err;
  logic [7:0]    o_count;
  logic [511:0]  chunk_1;
  logic [127:0]  chunk_2;
  logic [31:0]   difficulty;

  logic          s_data_en = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic [3:0]    s_data_sel = '0;
  logic          s_clear = 1'b0;
  logic          s_take = 1'b0;
  logic          s_full, s_valid, s_err;
  logic [4:0]    s_count;
  logic [63:0]   s_chunk_1;
  logic [63:0]   s_chunk_2;
  logic [31:0]   s_difficulty;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  header_bank_buffer dut (
    .clk(clk), .rst(rst), .i_data_en(i_data_en), .i_data(i_data),
    .i_data_sel(i_data_sel), .i_clear(i_clear), .i_take(i_take),
    .o_full(o_full), .o_valid(o_valid), .o_err(o_err), .o_count(o_count),
    .chunk_1(chunk_1), .chunk_2(chunk_2), .difficulty(difficulty)
  );

  header_bank_buffer #(
    .NUM_BYTES(16), .ADDR_W(4), .CHUNK1_BYTES(8), .TARGET_OFS(12), .TARGET_BYTES(4)
  ) dut16 (
    .clk(clk), .rst(rst), .i_data_en(s_data_en), .i_data(s_data),
    .i_data_sel(s_data_sel), .i_clear(s_clear), .i_take(s_take),
    .o_full(s_full), .o_valid(s_valid), .o_err(s_err), .o_count(s_count),
    .chunk_1(s_chunk_1), .chunk_2(s_chunk_2), .difficulty(s_difficulty)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    i_data_en  = 1'b1;
    i_data_sel = a;
    i_data     = d;
    step();
    i_data_en  = 1'b0;
  endtask

  function automatic logic [7:0] fb(input int idx);
    if (idx < 64) return chunk_1[idx*8 +: 8];
    return chunk_2[(idx-64)*8 +: 8];
  endfunction

  initial begin
    // reset
    step();
    step();
    rst = 1'b0;
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_full", 64'(o_full), 64'd0);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    chk("rst_chunk1_zero", 64'(chunk_1 == '0), 64'd1);
    chk("rst_diff", 64'(difficulty), 64'd0);

    // fill 0..79 with value = address
    for (int a = 0; a < 80; a++) begin
      wr(7'(a), 8'(a));
      chk("fill_count", 64'(o_count), 64'(a + 1));
      if (a == 78) chk("full_before_last", 64'(o_full), 64'd0);
    end
    chk("fill_full", 64'(o_full), 64'd1);
    chk("fill_chunks_hidden", 64'((chunk_1 == '0) && (chunk_2 == '0)), 64'd1);
    i_take = 1'b1;
    step();
    i_take = 1'b0;
    chk("swap_c1_5", 64'(chunk_1[5*8 +: 8]), 64'h05);
    chk("swap_c2_0", 64'(chunk_2[7:0]), 64'h40);
    chk("swap_diff", 64'(difficulty), 64'h4B4A4948);
    chk("swap_valid", 64'(o_valid), 64'd1);
    chk("swap_full", 64'(o_full), 64'd0);
    chk("swap_count", 64'(o_count), 64'd0);

    // overwrite, out-of-range rejects
    wr(7'd3, 8'hAA);
    wr(7'd3, 8'h55);
    chk("ovw_count", 64'(o_count), 64'd1);
    wr(7'd80, 8'h99);
    chk("oor_err", 64'(o_err), 64'd1);
    chk("oor_count", 64'(o_count), 64'd1);
    step();
    chk("oor_err_drop", 64'(o_err), 64'd0);
    wr(7'd100, 8'h01);
    chk("b2b_err1", 64'(o_err), 64'd1);
    wr(7'd127, 8'h02);
    chk("b2b_err2", 64'(o_err), 64'd1);
    step();
    chk("b2b_err_drop", 64'(o_err), 64'd0);
    for (int a = 0; a < 80; a++) if (a != 3) wr(7'(a), 8'(a) ^ 8'hC3);
    chk("hdr2_full", 64'(o_full), 64'd1);
    i_take = 1'b1;
    step();
    i_take = 1'b0;
    chk("hdr2_byte3", 64'(fb(3)), 64'h55);
    chk("hdr2_byte0", 64'(fb(0)), 64'hC3);

    // write while full is rejected; swap with simultaneous write
    for (int a = 0; a < 80; a++) wr(7'(a), 8'h10 + 8'(a));
    chk("hdr3_full", 64'(o_full), 64'd1);
    wr(7'd0, 8'hEE);
    chk("full_rej_err", 64'(o_err), 64'd1);
    chk("full_rej_count", 64'(o_count), 64'd80);
    chk("full_rej_front", 64'(fb(3)), 64'h55);
    step();
    chk("full_rej_err_drop", 64'(o_err), 64'd0);
    i_take = 1'b1;
    wr(7'd10, 8'h77);
    i_take = 1'b0;
    chk("swapwr_count", 64'(o_count), 64'd1);
    chk("swapwr_err", 64'(o_err), 64'd0);
    chk("swapwr_byte0", 64'(fb(0)), 64'h10);
    chk("swapwr_byte10", 64'(fb(10)), 64'h1A);
    chk("swapwr_diff", 64'(difficulty), 64'h5B5A5958);
    for (int a = 0; a < 80; a++) if (a != 10) wr(7'(a), 8'(a));
    chk("hdr4_full", 64'(o_full), 64'd1);
    i_take = 1'b1;
    step();
    i_take = 1'b0;
    chk("hdr4_byte10", 64'(fb(10)), 64'h77);
    chk("hdr4_byte11", 64'(fb(11)), 64'h0B);

    // clear beats take and write
    for (int a = 0; a < 40; a++) wr(7'(a), 8'hFF);
    chk("part_count", 64'(o_count), 64'd40);
    i_clear = 1'b1;
    i_take  = 1'b1;
    wr(7'd40, 8'h12);
    i_clear = 1'b0;
    i_take  = 1'b0;
    chk("clr_count", 64'(o_count), 64'd0);
    chk("clr_valid", 64'(o_valid), 64'd1);
    chk("clr_err", 64'(o_err), 64'd0);
    chk("clr_front", 64'(fb(10)), 64'h77);
    for (int a = 0; a < 80; a++) wr(7'(a), 8'h33);
    chk("clrfull_full", 64'(o_full), 64'd1);
    i_clear = 1'b1;
    i_take  = 1'b1;
    wr(7'd5, 8'h44);
    i_clear = 1'b0;
    i_take  = 1'b0;
    chk("clrfull_count", 64'(o_count), 64'd0);
    chk("clrfull_full0", 64'(o_full), 64'd0);
    chk("clrfull_err", 64'(o_err), 64'd0);
    chk("clrfull_front", 64'(fb(10)), 64'h77);
    i_take = 1'b1;
    step();
    i_take = 1'b0;
    chk("take_empty_front", 64'(fb(10)), 64'h77);
    chk("take_empty_valid", 64'(o_valid), 64'd1);

    // reset mid-fill with a write in flight
    for (int a = 0; a < 20; a++) wr(7'(a), 8'hA5);
    chk("mid_count", 64'(o_count), 64'd20);
    rst = 1'b1;
    wr(7'd20, 8'hA5);
    rst = 1'b0;
    chk("mrst_count", 64'(o_count), 64'd0);
    chk("mrst_valid", 64'(o_valid), 64'd0);
    chk("mrst_full", 64'(o_full), 64'd0);
    chk("mrst_err", 64'(o_err), 64'd0);
    chk("mrst_chunks_zero", 64'((chunk_1 == '0) && (chunk_2 == '0)), 64'd1);
    chk("mrst_diff", 64'(difficulty), 64'd0);

    // 16-byte instance
    for (int a = 0; a < 16; a++) begin
      s_data_en  = 1'b1;
      s_data_sel = 4'(a);
      s_data     = 8'hA0 + 8'(a);
      step();
      if (a == 14) chk("s_full_before", 64'(s_full), 64'd0);
    end
    s_data_en = 1'b0;
    chk("s_full", 64'(s_full), 64'd1);
    chk("s_count", 64'(s_count), 64'd16);
    s_take = 1'b1;
    step();
    s_take = 1'b0;
    chk("s_valid", 64'(s_valid), 64'd1);
    chk("s_chunk1", s_chunk_1, 64'hA7A6A5A4A3A2A1A0);
    chk("s_chunk2", s_chunk_2, 64'hAFAEADACABAAA9A8);
    chk("s_diff", 64'(s_difficulty), 64'hAFAEADAC);
    chk("s_count0", 64'(s_count), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/header_bank_buffer.md
# header_bank_buffer

Parametrised, double-buffered byte store for the block header. A byte-serial writer (the USB receive path) fills a back bank one addressed byte at a time, while the hashing core reads a stable front bank. The buffer tracks which bytes have been written and reports when the back bank holds a complete header. On a consumer request it swaps banks in one cycle, so the next header loads while the current one is being mined.

## Interface
- NUM_BYTES, 80, header length in bytes (bank depth)
- ADDR_W, 7, width of byte address; 2^ADDR_W >= NUM_BYTES
- CHUNK1_BYTES, 64, bytes presented on chunk_1; remaining NUM_BYTES-CHUNK1_BYTES on chunk_2
- TARGET_OFS, 72, byte offset of the difficulty/target field
- TARGET_BYTES, 4, length of the difficulty field

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- i_data_en  in  1  write strobe, one byte per cycle
- i_data  in  8  write byte
- i_data_sel  in  ADDR_W  byte address of i_data
- i_clear  in  1  discard back-bank contents
- i_take  in  1  consumer request to promote back bank to front
- o_full  out  1  back bank holds all NUM_BYTES bytes
- o_valid  out  1  front bank holds a promoted header
- o_err  out  1  one-cycle pulse on a rejected write
- o_count  out  ADDR_W+1  distinct bytes written in back bank
- chunk_1  out  CHUNK1_BYTES x 8  front bytes [CHUNK1_BYTES-1:0]
- chunk_2  out  (NUM_BYTES-CHUNK1_BYTES) x 8  front bytes [NUM_BYTES-1:CHUNK1_BYTES]
- difficulty  out  TARGET_BYTES x 8  front bytes [TARGET_OFS +: TARGET_BYTES]

## Operation
- Two banks of NUM_BYTES bytes each. A 1-bit bank pointer selects the front bank; the other bank is the back bank.
- Each byte has a written flag. o_count is the number of set flags.
- Back-bank state machine: EMPTY (count 0), FILLING (0 < count < NUM_BYTES), FULL (count == NUM_BYTES). o_full = (state == FULL).
- Accepted write: i_data_en=1, i_data_sel < NUM_BYTES, state != FULL, i_clear=0.
  - Stores the byte in the back bank.
  - If the flag was clear: sets the flag and increments count.
  - If the flag was already set: overwrites the byte; count is unchanged.
- Rejected write: i_data_en=1 with i_data_sel >= NUM_BYTES, or with state == FULL and no swap that cycle.
  - Data is dropped.
  - o_err pulses the next cycle.
  - A write dropped because i_clear is asserted does not raise o_err.
- Swap: i_take=1 and state == FULL and i_clear=0.
  - Toggles the bank pointer.
  - Sets o_valid=1.
  - Clears all flags and count; the old front bank becomes the new back bank.
  - i_take in any other state is ignored; o_valid and the front bank are unchanged.
- Write in the swap cycle: the write targets the new back bank (the old front). The byte is stored, its flag set, and count = 1.
- i_clear has the highest priority: it clears all back-bank flags and count to 0, and blocks a same-cycle swap and write. The front bank and o_valid are unaffected.
- chunk_1, chunk_2 and difficulty are driven combinationally from front-bank registers. Byte i maps to chunk_1[i] for i < CHUNK1_BYTES, otherwise to chunk_2[i-CHUNK1_BYTES].
- A difficulty field overlapping chunk_2 is legal; the bytes are shared.

## Timing
- Reset (rst=1 at an edge):
  - Both banks zeroed, all flags cleared, bank pointer 0.
  - o_full=0, o_valid=0, o_err=0, o_count=0.
  - chunk_1, chunk_2 and difficulty read all zeros.
- Reset mid-fill or in the same cycle as a swap or write overrides everything.
- Write latency: a byte written at edge N is in the back bank, with o_count/o_full updated, after edge N. It is not visible on the chunk outputs until a swap.
- Swap latency: i_take sampled at edge N. After edge N the outputs show the new front bank, o_valid=1, o_full=0 and o_count=0 (or 1 with a simultaneous write).
- o_full rises after the edge that accepts the final distinct byte.
- o_err is asserted for exactly the one cycle following each rejected write; back-to-back rejects give back-to-back pulses.
- Front-bank outputs are glitch-free across a fill: they change only on the swap edge.

## Test plan
- Reset, then write bytes 0..79 with value = address, one per cycle. o_count steps 1..80, o_full=1 after the 80th edge, and the chunk outputs stay 0. Pulse i_take: chunk_1[5]=0x05, chunk_2[0]=0x40, difficulty={0x4B,0x4A,0x49,0x48}, o_valid=1, o_full=0.
- Write address 3 twice (0xAA then 0x55). o_count=1 and byte 3 = 0x55 after the fill and swap. Then write address 80: o_err pulses once and o_count is unchanged.
- Fill the back bank fully, then write address 0 without i_take. o_err=1 for one cycle and the contents are unchanged. Assert i_take together with a write of 0x77 to address 10: swap occurs, o_count=1, and the new back byte 10 = 0x77.
- Fill 40 bytes, then assert i_clear together with i_take and a write. o_count=0, no swap, o_valid unchanged, no o_err.
- Promote header A, fill header B, then assert rst mid-fill at o_count=20. All outputs are 0 on the next cycle, including o_valid and chunk_1.
- Re-run with NUM_BYTES=16, CHUNK1_BYTES=8, TARGET_OFS=12, ADDR_W=4. o_full after 16 writes and difficulty equals bytes 12..15.
